// File: rtl/rx_fifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// rx_fifo_drain_ctrl
//
// Read-side controller for the receive FIFO. Pops bytes from a
// first-word-fall-through FIFO and packs them little-endian into 32-bit words
// for the downstream packet buffer (valid/ready). A word is closed when it
// holds 4 bytes, when an end-of-packet is pending and the FIFO has drained
// (word_last=1, possibly zero-length), or after TIMEOUT_CYCLES idle cycles
// with a partial word (word_last=0).
//
// Ports:
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   fifo_empty    in   FIFO empty flag
//   fifo_rdata    in   FIFO head byte, valid while fifo_empty=0
//   fifo_r_enable out  pop strobe, head consumed at the same rising edge
//   eop           in   one-cycle end-of-packet pulse from the receiver
//   clear         in   synchronous abort of the current word/packet
//   word_out      out  packed word, first byte in [7:0], unused lanes 0
//   word_bytes    out  valid byte count 0..4
//   word_last     out  word closes the packet
//   word_valid    out  word available
//   word_ready    in   downstream accepts the word when word_valid=1
// ---------------------------------------------------------------------------
module rx_fifo_drain_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rdata,
    output logic        fifo_r_enable,
    input  logic        eop,
    input  logic        clear,
    output logic [31:0] word_out,
    output logic [2:0]  word_bytes,
    output logic        word_last,
    output logic        word_valid,
    input  logic        word_ready
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST =
        (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TIMEOUT_ON = (TIMEOUT_CYCLES > 0);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]    r_state;
    logic [2:0]    r_byte_cnt;
    logic [TW-1:0] r_timer;
    logic          r_eop_pending;
    logic [31:0]   r_shift;
    logic [31:0]   r_word_out;
    logic [2:0]    r_word_bytes;
    logic          r_word_last;

    logic        w_in_fill;
    logic        w_full;
    logic        w_has_bytes;
    logic        w_flush_full;
    logic        w_flush_eop;
    logic        w_flush_tmo;
    logic        w_flush;
    logic        w_pop;
    logic        w_tick;
    logic        w_accept;
    logic [31:0] w_shift_loaded;

    // Decision terms for FILL, ordered by priority: clear, full word,
    // drained end-of-packet, idle timeout, pop.
    assign w_in_fill    = (r_state == ST_FILL);
    assign w_full       = (r_byte_cnt == 3'd4);
    assign w_has_bytes  = (r_byte_cnt != 3'd0);
    assign w_flush_full = w_in_fill & ~clear & w_full;
    assign w_flush_eop  = w_in_fill & ~clear & ~w_full & fifo_empty & r_eop_pending;
    assign w_flush_tmo  = w_in_fill & ~clear & ~w_full & fifo_empty & ~r_eop_pending
                        & TIMEOUT_ON & w_has_bytes & (r_timer == TIMER_LAST);
    assign w_flush      = w_flush_full | w_flush_eop | w_flush_tmo;
    assign w_pop        = w_in_fill & ~clear & ~w_full & ~fifo_empty;

    // The idle timer only runs while a partial word waits on an empty FIFO
    // with no packet end in sight; a pending eop closes the word instead.
    assign w_tick   = w_in_fill & ~clear & fifo_empty & w_has_bytes
                    & ~r_eop_pending & ~w_flush & TIMEOUT_ON;
    assign w_accept = (r_state == ST_HOLD) & word_ready;

    // Pop is combinational on the FIFO flag; gating with n_rst keeps the
    // FIFO untouched while the block is held in reset.
    assign fifo_r_enable = w_pop & n_rst;

    assign word_out   = r_word_out;
    assign word_bytes = r_word_bytes;
    assign word_last  = r_word_last;
    assign word_valid = (r_state == ST_HOLD);

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_shift_loaded = r_shift;
        for (int lane = 0; lane < 4; lane++) begin
            if (r_byte_cnt == 3'(lane)) begin
                w_shift_loaded[lane*8 +: 8] = fifo_rdata;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= ST_FILL;
            r_byte_cnt    <= 3'd0;
            r_timer       <= '0;
            r_eop_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: if (w_flush)             r_state <= ST_HOLD;
                ST_HOLD: if (clear | word_ready)  r_state <= ST_FILL;
                default:                          r_state <= ST_FILL;
            endcase

            if (clear | w_flush)  r_byte_cnt <= 3'd0;
            else if (w_pop)       r_byte_cnt <= r_byte_cnt + 3'd1;

            if (clear | w_flush | w_pop) r_timer <= '0;
            else if (w_tick)             r_timer <= r_timer + 1'b1;

            // clear beats a same-cycle eop; a new eop beats the clear that
            // accepting the previous packet's last word would cause.
            if (clear)                          r_eop_pending <= 1'b0;
            else if (eop)                       r_eop_pending <= 1'b1;
            else if (w_accept & r_word_last)    r_eop_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shift      <= 32'd0;
            r_word_out   <= 32'd0;
            r_word_bytes <= 3'd0;
            r_word_last  <= 1'b0;
        end else begin
            if (clear | w_flush) r_shift <= 32'd0;
            else if (w_pop)      r_shift <= w_shift_loaded;

            // Output word is captured once at flush and held through HOLD.
            if (w_flush) begin
                r_word_out   <= r_shift;
                r_word_bytes <= r_byte_cnt;
                r_word_last  <= w_flush_eop;
            end
        end
    end

endmodule

// File: tb/tb_rx_fifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_fifo_drain_ctrl
//
// Directed bench for rx_fifo_drain_ctrl. A queue stands in for the receive
// FIFO; a transaction-level model (byte queue, idle count, pending flag,
// held word) predicts every output each cycle, and each scenario ends with
// literal expectations on the words the downstream side accepted.
// ---------------------------------------------------------------------------
module tb_rx_fifo_drain_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_r_enable;
    logic        eop;
    logic        clear;
    logic [31:0] word_out;
    logic [2:0]  word_bytes;
    logic        word_last;
    logic        word_valid;
    logic        word_ready;

    rx_fifo_drain_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .fifo_empty    (fifo_empty),
        .fifo_rdata    (fifo_rdata),
        .fifo_r_enable (fifo_r_enable),
        .eop           (eop),
        .clear         (clear),
        .word_out      (word_out),
        .word_bytes    (word_bytes),
        .word_last     (word_last),
        .word_valid    (word_valid),
        .word_ready    (word_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO stand-in ----------------
    logic [7:0] fq[$];

    task automatic fifo_refresh();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_refresh();
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_cur[$];
    int          m_idle;
    bit          m_pending;
    bit          m_hold;
    logic [31:0] m_data;
    int          m_bytes;
    bit          m_last;

    bit          s_empty, s_eop, s_clear, s_ready, s_pop, s_rst;
    logic [7:0]  s_rdata;

    typedef struct {
        logic [31:0] data;
        int          bytes;
        bit          last;
    } word_t;
    word_t acc[$];
    int    n_valid_cycles;
    int    n_pops;

    task automatic model_reset();
        m_cur.delete();
        m_idle    = 0;
        m_pending = 0;
        m_hold    = 0;
        m_data    = 0;
        m_bytes   = 0;
        m_last    = 0;
    endtask

    task automatic close_word(input bit last);
        logic [31:0] v = 32'd0;
        foreach (m_cur[i]) v |= 32'(m_cur[i]) << (8 * i);
        m_data  = v;
        m_bytes = m_cur.size();
        m_last  = last;
        m_hold  = 1;
        m_cur.delete();
        m_idle  = 0;
    endtask

    task automatic model_step();
        if (!m_hold) begin
            if (s_clear) begin
                m_cur.delete();
                m_idle    = 0;
                m_pending = 0;
            end else if (m_cur.size() == 4) begin
                close_word(1'b0);
            end else if (s_empty && m_pending) begin
                close_word(1'b1);
            end else if (s_empty && T > 0 && m_cur.size() > 0 && m_idle == T - 1) begin
                close_word(1'b0);
            end else if (!s_empty) begin
                m_cur.push_back(s_rdata);
                m_idle = 0;
            end else if (m_cur.size() > 0 && !m_pending) begin
                m_idle++;
            end
        end else begin
            if (s_clear) begin
                m_hold    = 0;
                m_pending = 0;
            end else if (s_ready) begin
                m_hold = 0;
                if (m_last) m_pending = 0;
            end
        end
        if (!s_clear && s_eop) m_pending = 1;
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        bit e_pop;
        model_reset();
        forever begin
            @(negedge clk);
            #2;
            if (!n_rst) model_reset();
            e_pop = n_rst && !m_hold && !clear && (m_cur.size() < 4) && !fifo_empty;
            check("word_valid", 32'(word_valid), 32'(n_rst && m_hold));
            check("fifo_r_enable", 32'(fifo_r_enable), 32'(e_pop));
            if (!n_rst || m_hold) begin
                check("word_out", word_out, n_rst ? m_data : 32'd0);
                check("word_bytes", 32'(word_bytes), n_rst ? 32'(m_bytes) : 32'd0);
                check("word_last", 32'(word_last), n_rst ? 32'(m_last) : 32'd0);
            end
            if (word_valid) n_valid_cycles++;
            if (n_rst && word_valid && word_ready && !clear)
                acc.push_back('{data: word_out, bytes: int'(word_bytes), last: word_last});
            s_empty = fifo_empty;
            s_rdata = fifo_rdata;
            s_eop   = eop;
            s_clear = clear;
            s_ready = word_ready;
            s_pop   = fifo_r_enable;
            s_rst   = n_rst;
            @(posedge clk);
            #1;
            if (s_pop && fq.size() > 0) begin
                void'(fq.pop_front());
                n_pops++;
            end
            fifo_refresh();
            if (s_rst) model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_test();
        acc.delete();
        n_valid_cycles = 0;
        n_pops         = 0;
    endtask

    task automatic expect_word(input int idx, input logic [31:0] d, input int b, input bit l);
        if (acc.size() > idx) begin
            check($sformatf("acc%0d_data", idx), acc[idx].data, d);
            check($sformatf("acc%0d_bytes", idx), 32'(acc[idx].bytes), 32'(b));
            check($sformatf("acc%0d_last", idx), 32'(acc[idx].last), 32'(l));
        end
    endtask

    task automatic wait_valid(input string name, input int limit, output int took);
        took = 0;
        while (!word_valid && took < limit) begin
            @(negedge clk);
            took++;
        end
        check(name, 32'(word_valid), 32'd1);
    endtask

    initial begin
        int took;
        n_rst      = 1'b0;
        eop        = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b1;
        fifo_refresh();
        cyc(2);
        #3;
        check("rst_word_out", word_out, 32'd0);
        check("rst_word_bytes", 32'(word_bytes), 32'd0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_fifo_r_enable", 32'(fifo_r_enable), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        cyc(2);

        // Full word, no eop.
        start_test();
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        cyc(10);
        check("t1_words", 32'(acc.size()), 32'd1);
        expect_word(0, 32'hD4C3B2A1, 4, 1'b0);
        check("t1_valid_cycles", 32'(n_valid_cycles), 32'd1);
        check("t1_pops", 32'(n_pops), 32'd4);

        // Partial word closed by eop.
        start_test();
        push(8'h11); push(8'h22); push(8'h33);
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
        cyc(10);
        check("t2_words", 32'(acc.size()), 32'd1);
        expect_word(0, 32'h00332211, 3, 1'b1);

        // Exactly 4 bytes then eop: full word plus zero-length marker.
        start_test();
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
        cyc(15);
        check("t3_words", 32'(acc.size()), 32'd2);
        expect_word(0, 32'h44434241, 4, 1'b0);
        expect_word(1, 32'h00000000, 0, 1'b1);

        // Idle timeout on a 2-byte partial word, then a fresh word at lane 0.
        start_test();
        push(8'h55); push(8'h66);
        @(negedge clk);
        wait_valid("t4_timeout_seen", 40, took);
        check("t4_timeout_latency", 32'(took + 1), 32'd18);
        cyc(3);
        push(8'h77);
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
        cyc(10);
        check("t4_words", 32'(acc.size()), 32'd2);
        expect_word(0, 32'h00006655, 2, 1'b0);
        expect_word(1, 32'h00000077, 1, 1'b1);

        // Backpressure: no pops while a word is held.
        start_test();
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        cyc(16);
        check("t5_words_stalled", 32'(acc.size()), 32'd0);
        check("t5_pops_stalled", 32'(n_pops), 32'd4);
        word_ready = 1'b1;
        cyc(15);
        check("t5_words", 32'(acc.size()), 32'd2);
        expect_word(0, 32'hC3C2C1C0, 4, 1'b0);
        expect_word(1, 32'hC7C6C5C4, 4, 1'b0);
        check("t5_pops", 32'(n_pops), 32'd8);

        // clear during a partial word, with a concurrent eop that is lost.
        start_test();
        push(8'hE1); push(8'hE2);
        cyc(4);
        clear = 1'b1;
        eop   = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        eop   = 1'b0;
        cyc(2);
        push(8'hF1);
        cyc(25);
        check("t6_words", 32'(acc.size()), 32'd1);
        expect_word(0, 32'h000000F1, 1, 1'b0);

        // clear while holding a word drops it.
        start_test();
        word_ready = 1'b0;
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        wait_valid("t7_hold_seen", 20, took);
        clear = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        word_ready = 1'b1;
        #3;
        check("t7_valid_after_clear", 32'(word_valid), 32'd0);
        cyc(5);
        check("t7_words", 32'(acc.size()), 32'd0);

        // Reset pulse while holding a word.
        start_test();
        word_ready = 1'b0;
        push(8'h91); push(8'h92); push(8'h93); push(8'h94);
        wait_valid("t8_hold_seen", 20, took);
        n_rst = 1'b0;
        #3;
        check("t8_valid_in_reset", 32'(word_valid), 32'd0);
        @(negedge clk);
        n_rst      = 1'b1;
        word_ready = 1'b1;
        cyc(3);
        check("t8_words_dropped", 32'(acc.size()), 32'd0);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        cyc(10);
        check("t8_words", 32'(acc.size()), 32'd1);
        expect_word(0, 32'h04030201, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
